// File: rtl/pwm_meas_pkg.sv
// Shared types and constants for the PWM duty meter.
package pwm_meas_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  localparam int CLK_HZ = 27000000;
  localparam int PCT_W  = 7;

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Measurement bus of the PWM duty meter: waveform in, results and flags out.
interface pwm_duty_meter_if
  import pwm_meas_pkg::*;
#(
  parameter int CNT_W = 28
);
  logic             sig_in;
  logic             meas_valid;
  logic [CNT_W-1:0] high_cyc;
  logic [CNT_W-1:0] low_cyc;
  logic [CNT_W:0]   period_cyc;
  logic             stuck_hi;
  logic             stuck_lo;
  logic             pct_valid;
  logic [PCT_W-1:0] duty_pct;

  modport master (
    output sig_in,
    input  meas_valid, high_cyc, low_cyc, period_cyc,
    input  stuck_hi, stuck_lo, pct_valid, duty_pct
  );

  modport slave (
    input  sig_in,
    output meas_valid, high_cyc, low_cyc, period_cyc,
    output stuck_hi, stuck_lo, pct_valid, duty_pct
  );
endinterface

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider producing a PCT_W-bit quotient, one bit per cycle.
// A start pulse loads operands (aborting any division in flight); done pulses PCT_W cycles later.
module pwm_duty_div
  import pwm_meas_pkg::*;
#(
  parameter int NUM_W = 35,
  parameter int DEN_W = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             done_o,
  output logic [PCT_W-1:0] quo_o
);
  localparam int RW = NUM_W + 1;

  logic [RW-1:0]    rem_q;
  logic [RW-1:0]    dsh_q;
  logic [PCT_W-1:0] q_q;
  logic [PCT_W-1:0] quo_q;
  logic [2:0]       step_q;
  logic             busy_q;
  logic             done_q;
  logic             ge;

  // Caller guarantees num < den * 2**PCT_W, so the quotient never overflows.
  assign ge = (rem_q >= dsh_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      q_q    <= '0;
      quo_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= RW'(num_i);
        dsh_q  <= RW'(den_i) << (PCT_W - 1);
        q_q    <= '0;
        step_q <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (ge) rem_q <= rem_q - dsh_q;
        dsh_q <= dsh_q >> 1;
        q_q   <= {q_q[PCT_W-2:0], ge};
        if (step_q == 3'(PCT_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          quo_q  <= {q_q[PCT_W-2:0], ge};
        end else begin
          step_q <= step_q + 3'd1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign quo_o  = quo_q;
endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high/low/period of an asynchronous on/off waveform and flags stuck levels.
// Define DUTY_PCT_EN to add the duty-percent divider (pct_valid/duty_pct otherwise tied 0).
//
//  state     | meaning
//  WAIT_RISE | idle after reset or timeout; next rise starts a period
//  MEAS_HIGH | counting the high level
//  MEAS_LOW  | counting the low level; next rise closes the period
module pwm_duty_meter
  import pwm_meas_pkg::*;
#(
  parameter int CNT_W       = 28,
  parameter int TIMEOUT_CYC = 108000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  pwm_duty_meter_if.slave   bus
);
  if ($clog2(TIMEOUT_CYC + 1) > CNT_W) begin : g_cnt_w_chk
    $error("CNT_W too narrow for TIMEOUT_CYC");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("SYNC_STAGES must be at least 2");
  end

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d_q;
  logic                   rise_q;
  logic                   fall_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             valid_q, valid_d;
  logic             shi_q, shi_d;
  logic             slo_q, slo_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Edges are registered, giving the rise-to-meas_valid latency of SYNC_STAGES+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      s_d_q  <= s;
      rise_q <= s & ~s_d_q;
      fall_q <= ~s & s_d_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    high_d   = high_q;
    low_d    = low_q;
    period_d = period_q;
    valid_d  = 1'b0;
    shi_d    = shi_q;
    slo_d    = slo_q;
    case (state_q)
      WAIT_RISE: begin
        if (rise_q) begin
          cnt_d   = CNT_W'(1);
          shi_d   = 1'b0;
          slo_d   = 1'b0;
          state_d = MEAS_HIGH;
        end
      end
      MEAS_HIGH: begin
        if (fall_q) begin
          hcnt_d  = cnt_q;
          cnt_d   = CNT_W'(1);
          state_d = MEAS_LOW;
        end else if (cnt_q == TO_CNT) begin
          shi_d   = 1'b1;
          state_d = WAIT_RISE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEAS_LOW: begin
        if (rise_q) begin
          high_d   = hcnt_q;
          low_d    = cnt_q;
          period_d = {1'b0, hcnt_q} + {1'b0, cnt_q};
          valid_d  = 1'b1;
          shi_d    = 1'b0;
          slo_d    = 1'b0;
          cnt_d    = CNT_W'(1);
          state_d  = MEAS_HIGH;
        end else if (cnt_q == TO_CNT) begin
          slo_d   = 1'b1;
          state_d = WAIT_RISE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = WAIT_RISE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= WAIT_RISE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      shi_q    <= 1'b0;
      slo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      high_q   <= high_d;
      low_q    <= low_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      shi_q    <= shi_d;
      slo_q    <= slo_d;
    end
  end

  assign bus.meas_valid = valid_q;
  assign bus.high_cyc   = high_q;
  assign bus.low_cyc    = low_q;
  assign bus.period_cyc = period_q;
  assign bus.stuck_hi   = shi_q;
  assign bus.stuck_lo   = slo_q;

`ifdef DUTY_PCT_EN
  logic [CNT_W+6:0] pct_num;

  assign pct_num = (CNT_W+7)'(high_q) * (CNT_W+7)'(100);

  pwm_duty_div #(
    .NUM_W (CNT_W + 7),
    .DEN_W (CNT_W + 1)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (valid_q),
    .num_i   (pct_num),
    .den_i   (period_q),
    .done_o  (bus.pct_valid),
    .quo_o   (bus.duty_pct)
  );
`else
  assign bus.pct_valid = 1'b0;
  assign bus.duty_pct  = '0;
`endif
endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter: timestamp-based reference model plus table and corner cases.
module tb_pwm_duty_meter;
  localparam int CNT_W = 28;
  localparam int T     = 100;
  localparam int SS    = 2;
  localparam int LAT   = SS + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pwm_duty_meter_if #(.CNT_W(CNT_W)) bus ();

  pwm_duty_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (T),
    .SYNC_STAGES (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: works on timestamps of input edges as sampled by the first sync flop.
  int hist[$];
  int have_r0, r0, have_f, f;
  int e_valid, e_high, e_low, e_per, e_shi, e_slo, e_pv, e_pct;
  int pend, pend_due, pend_val;

  task model_reset();
    hist.delete();
    have_r0 = 0; r0 = 0; have_f = 0; f = 0;
    e_valid = 0; e_high = 0; e_low = 0; e_per = 0;
    e_shi = 0; e_slo = 0; e_pv = 0; e_pct = 0;
    pend = 0; pend_due = 0; pend_val = 0;
  endtask

  task model_step();
    int n, m, cur, prv, rise, fall;
    n = hist.size() - 1;
    m = n - LAT;
    e_valid = 0;
    e_pv    = 0;
    if (pend != 0 && pend_due == n) begin
      e_pv = 1; e_pct = pend_val; pend = 0;
    end
    if (m >= 0) begin
      cur  = hist[m];
      prv  = (m > 0) ? hist[m-1] : 0;
      rise = (cur == 1 && prv == 0) ? 1 : 0;
      fall = (cur == 0 && prv == 1) ? 1 : 0;
      if (rise != 0) begin
        if (have_r0 != 0 && have_f != 0) begin
          e_valid = 1;
          e_high  = f - r0;
          e_low   = m - f;
          e_per   = m - r0;
`ifdef DUTY_PCT_EN
          pend = 1; pend_due = n + 8; pend_val = (e_high * 100) / e_per;
`endif
        end
        e_shi = 0; e_slo = 0;
        have_r0 = 1; r0 = m; have_f = 0;
      end else begin
        if (fall != 0 && have_r0 != 0) begin
          have_f = 1; f = m;
        end
        if (have_r0 != 0 && have_f == 0 && m - r0 == T) begin
          e_shi = 1; have_r0 = 0;
        end else if (have_f != 0 && m - f == T) begin
          e_slo = 1; have_r0 = 0; have_f = 0;
        end
      end
    end
  endtask

  int n_valid, n_pct, last_high, last_low, last_per, last_pct, seen_shi, seen_slo;

  always @(posedge clk) begin
    if (!rst) model_reset();
    else begin
      hist.push_back(int'(bus.sig_in));
      model_step();
    end
    #1;
    chk("meas_valid", 64'(bus.meas_valid), 64'(e_valid));
    chk("high_cyc",   64'(bus.high_cyc),   64'(e_high));
    chk("low_cyc",    64'(bus.low_cyc),    64'(e_low));
    chk("period_cyc", 64'(bus.period_cyc), 64'(e_per));
    chk("stuck_hi",   64'(bus.stuck_hi),   64'(e_shi));
    chk("stuck_lo",   64'(bus.stuck_lo),   64'(e_slo));
    chk("pct_valid",  64'(bus.pct_valid),  64'(e_pv));
    chk("duty_pct",   64'(bus.duty_pct),   64'(e_pct));
    if (bus.meas_valid === 1'b1) begin
      n_valid++;
      last_high = int'(bus.high_cyc);
      last_low  = int'(bus.low_cyc);
      last_per  = int'(bus.period_cyc);
    end
    if (bus.pct_valid === 1'b1) begin
      n_pct++;
      last_pct = int'(bus.duty_pct);
    end
    if (bus.stuck_hi === 1'b1) seen_shi = 1;
    if (bus.stuck_lo === 1'b1) seen_slo = 1;
  end

  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.sig_in = lvl;
    end
  endtask

  typedef struct {
    int h; int l; int reps;
    int x_high; int x_low; int x_per; int x_pct; int x_npct;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Each entry is followed by one closing high and a 120-cycle low (parks in stuck_lo).
    vecs[0] = '{20, 10, 4, 20, 10, 30, 66, 4};
    vecs[1] = '{ 8,  8, 4,  8,  8, 16, 50, 4};
    vecs[2] = '{ 1,  1, 6,  1,  1,  2, 50, 1};
    vecs[3] = '{100,100,2,100,100,200, 50, 2};
    vecs[4] = '{ 3, 97, 2,  3, 97,100,  3, 2};
    vecs[5] = '{ 1,  7, 3,  1,  7,  8, 12, 3};
    vecs[6] = '{ 2,  5, 3,  2,  5,  7, 28, 1};

    model_reset();
    n_valid = 0; n_pct = 0; last_high = 0; last_low = 0; last_per = 0; last_pct = 0;
    seen_shi = 0; seen_slo = 0;
    bus.sig_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5);

    for (int i = 0; i < 7; i++) begin
      n_valid = 0; n_pct = 0;
      for (int r = 0; r < vecs[i].reps; r++) begin
        drive(1'b1, vecs[i].h);
        drive(1'b0, vecs[i].l);
      end
      drive(1'b1, vecs[i].h);
      drive(1'b0, 120);
      chk($sformatf("tbl%0d_nvalid", i), 64'(n_valid), 64'(vecs[i].reps));
      chk($sformatf("tbl%0d_high", i),   64'(last_high), 64'(vecs[i].x_high));
      chk($sformatf("tbl%0d_low", i),    64'(last_low),  64'(vecs[i].x_low));
      chk($sformatf("tbl%0d_period", i), 64'(last_per),  64'(vecs[i].x_per));
      chk($sformatf("tbl%0d_stuck_lo", i), 64'(bus.stuck_lo), 64'(1));
`ifdef DUTY_PCT_EN
      chk($sformatf("tbl%0d_npct", i), 64'(n_pct), 64'(vecs[i].x_npct));
      chk($sformatf("tbl%0d_pct", i),  64'(last_pct), 64'(vecs[i].x_pct));
`else
      chk($sformatf("tbl%0d_npct", i), 64'(n_pct), 64'(0));
`endif
    end

    // High held one cycle past the timeout.
    n_valid = 0; seen_shi = 0;
    drive(1'b1, 101);
    drive(1'b0, 10);
    chk("shi_seen", 64'(seen_shi), 64'(1));
    chk("shi_sticky", 64'(bus.stuck_hi), 64'(1));
    chk("shi_nvalid", 64'(n_valid), 64'(0));
    drive(1'b1, 20);
    chk("shi_cleared", 64'(bus.stuck_hi), 64'(0));
    drive(1'b0, 10);
    drive(1'b1, 5);
    chk("shi_after_nvalid", 64'(n_valid), 64'(1));
    chk("shi_after_high", 64'(last_high), 64'(20));
    chk("shi_after_low", 64'(last_low), 64'(10));
    drive(1'b0, 120);

    // Low held one cycle past the timeout.
    drive(1'b1, 5);
    seen_slo = 0; n_valid = 0;
    drive(1'b0, 10);
    drive(1'b1, 5);
    chk("slo_pre_nvalid", 64'(n_valid), 64'(1));
    drive(1'b0, 101);
    drive(1'b1, 5);
    chk("slo_seen", 64'(seen_slo), 64'(1));
    chk("slo_nvalid", 64'(n_valid), 64'(1));
    drive(1'b0, 10);
    drive(1'b1, 5);
    chk("slo_after_nvalid", 64'(n_valid), 64'(2));
    chk("slo_after_low", 64'(last_low), 64'(10));
    drive(1'b0, 120);

    // Asynchronous reset while measuring the low level.
    drive(1'b1, 20);
    drive(1'b0, 10);
    drive(1'b1, 20);
    drive(1'b0, 5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_meas_valid", 64'(bus.meas_valid), 64'(0));
    chk("rst_high",       64'(bus.high_cyc),   64'(0));
    chk("rst_low",        64'(bus.low_cyc),    64'(0));
    chk("rst_period",     64'(bus.period_cyc), 64'(0));
    chk("rst_stuck",      64'({bus.stuck_hi, bus.stuck_lo}), 64'(0));
    chk("rst_pct",        64'({bus.pct_valid, bus.duty_pct}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_valid = 0;
    drive(1'b0, 5);
    drive(1'b1, 20);
    drive(1'b0, 10);
    chk("rst_first_rise", 64'(n_valid), 64'(0));
    drive(1'b1, 20);
    chk("rst_after_nvalid", 64'(n_valid), 64'(1));
    chk("rst_after_high", 64'(last_high), 64'(20));
    chk("rst_after_low", 64'(last_low), 64'(10));
    drive(1'b0, 120);

    // Random levels, some beyond the timeout.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, int'($urandom_range(1, 110)));
      drive(1'b0, int'($urandom_range(1, 110)));
    end
    drive(1'b0, 120);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
